// File: rtl/ascon_frame_sched.sv
// ascon_frame_sched: sequences one Ascon frame (init, AD, plaintext blocks, final block, tag) against a core handshake
module ascon_frame_sched #(
    parameter int MAX_BLOCKS     = 23,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic         clock_i,
    input  logic         reset_i,
    input  logic         start_i,
    input  logic [4:0]   nb_blocks_i,
    input  logic [127:0] key_i,
    input  logic [127:0] nonce_i,
    input  logic [63:0]  ad_i,
    input  logic [63:0]  pt_data_i,
    input  logic         pt_valid_i,
    output logic         pt_ready_o,
    output logic         init_o,
    output logic         associate_data_o,
    output logic         finalisation_o,
    output logic [63:0]  data_o,
    output logic         data_valid_o,
    output logic [127:0] key_o,
    output logic [127:0] nonce_o,
    input  logic         end_initialisation_i,
    input  logic         end_associate_i,
    input  logic [63:0]  cipher_i,
    input  logic         cipher_valid_i,
    input  logic         end_cipher_i,
    input  logic [127:0] tag_i,
    input  logic         end_tag_i,
    output logic [63:0]  ct_data_o,
    output logic         ct_valid_o,
    input  logic         ct_ready_i,
    output logic [127:0] tag_o,
    output logic         tag_valid_o,
    output logic         busy_o,
    output logic         err_o,
    output logic [1:0]   err_code_o
);
    typedef enum logic [3:0] {
        IDLE, INIT, WAIT_INIT, AD_SEND, WAIT_AD, PT_FETCH, PT_SEND, WAIT_CIPHER,
        CT_OUT, WAIT_END, FIN_SEND, WAIT_FCIPHER, FIN_CT_OUT, WAIT_TAG, ERROR
    } state_t;

    localparam int            TW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [5:0]    MAXB  = 6'(MAX_BLOCKS);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

    state_t        state, state_d;
    logic [63:0]   ad_r, pt_r, data_q;
    logic [4:0]    nb_r, blk_cnt;
    logic [TW-1:0] tmo;
    logic          end_flag, tag_flag;
    logic [127:0]  tag_h;
    logic          start_ok, in_wait, timed_out, end_seen, tag_seen, tag_done;

    assign init_o           = state == INIT;
    assign associate_data_o = state == AD_SEND;
    assign data_valid_o     = state inside {AD_SEND, PT_SEND, FIN_SEND};
    assign finalisation_o   = state inside {FIN_SEND, WAIT_FCIPHER, FIN_CT_OUT, WAIT_TAG};
    assign data_o           = associate_data_o ? ad_r : (data_valid_o ? pt_r : data_q);
    assign pt_ready_o       = state == PT_FETCH;
    assign ct_valid_o       = state inside {CT_OUT, FIN_CT_OUT};
    assign busy_o           = !(state inside {IDLE, ERROR});
    assign err_o            = state == ERROR;

    // next-state selection; a timeout only wins when no legitimate exit is taken that cycle
    always_comb begin
        start_ok  = ({1'b0, nb_blocks_i} >= 6'd1) && ({1'b0, nb_blocks_i} <= MAXB);
        in_wait   = state inside {WAIT_INIT, WAIT_AD, WAIT_CIPHER, WAIT_END, WAIT_FCIPHER, WAIT_TAG};
        timed_out = in_wait && tmo == TLAST;
        end_seen  = end_flag || end_cipher_i;
        tag_seen  = tag_flag || end_tag_i;
        state_d   = state;
        case (state)
            IDLE:         if (start_i) state_d = start_ok ? INIT : ERROR;
            INIT:         state_d = WAIT_INIT;
            WAIT_INIT:    if (end_initialisation_i) state_d = AD_SEND;
            AD_SEND:      state_d = WAIT_AD;
            WAIT_AD:      if (end_associate_i) state_d = PT_FETCH;
            PT_FETCH:     if (pt_valid_i) state_d = (blk_cnt + 5'd1 < nb_r) ? PT_SEND : FIN_SEND;
            PT_SEND:      state_d = WAIT_CIPHER;
            WAIT_CIPHER:  if (cipher_valid_i) state_d = CT_OUT;
            CT_OUT:       if (ct_ready_i) state_d = end_seen ? PT_FETCH : WAIT_END;
            WAIT_END:     if (end_seen) state_d = PT_FETCH;
            FIN_SEND:     state_d = WAIT_FCIPHER;
            WAIT_FCIPHER: if (cipher_valid_i) state_d = FIN_CT_OUT;
            FIN_CT_OUT:   if (ct_ready_i) state_d = tag_seen ? IDLE : WAIT_TAG;
            WAIT_TAG:     if (end_tag_i) state_d = IDLE;
            ERROR:        if (start_i) state_d = IDLE;
            default:      state_d = IDLE;
        endcase
        if (timed_out && state_d == state) state_d = ERROR;
        tag_done = (state == FIN_CT_OUT || state == WAIT_TAG) && state_d == IDLE;
    end

    // state register
    always_ff @(posedge clock_i) begin
        if (reset_i) state <= IDLE;
        else state <= state_d;
    end

    // datapath: frame parameters, data words, sticky end/tag flags, counters and error code
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            key_o       <= '0;
            nonce_o     <= '0;
            ad_r        <= '0;
            nb_r        <= '0;
            pt_r        <= '0;
            data_q      <= '0;
            ct_data_o   <= '0;
            tag_o       <= '0;
            tag_h       <= '0;
            tag_valid_o <= 1'b0;
            blk_cnt     <= '0;
            tmo         <= '0;
            end_flag    <= 1'b0;
            tag_flag    <= 1'b0;
            err_code_o  <= 2'b00;
        end else begin
            data_q      <= data_o;
            tag_valid_o <= tag_done;
            tmo         <= (state_d == state && in_wait) ? tmo + 1'b1 : '0;
            if (state == IDLE && start_i && start_ok) begin
                key_o   <= key_i;
                nonce_o <= nonce_i;
                ad_r    <= ad_i;
                nb_r    <= nb_blocks_i;
            end
            if (state == IDLE) blk_cnt <= '0;
            else if (state == PT_FETCH && pt_valid_i) begin
                pt_r    <= pt_data_i;
                blk_cnt <= blk_cnt + 5'd1;
            end
            if ((state == WAIT_CIPHER || state == WAIT_FCIPHER) && cipher_valid_i) ct_data_o <= cipher_i;
            if (state == IDLE || state_d == PT_FETCH) end_flag <= 1'b0;
            else if ((state == WAIT_CIPHER || state == CT_OUT) && end_cipher_i) end_flag <= 1'b1;
            if (state == IDLE || state_d == IDLE) tag_flag <= 1'b0;
            else if ((state == WAIT_FCIPHER || state == FIN_CT_OUT) && end_tag_i) begin
                tag_flag <= 1'b1;
                tag_h    <= tag_i;
            end
            if (tag_done) tag_o <= tag_flag ? tag_h : tag_i;
            if (state == IDLE && start_i && !start_ok) err_code_o <= 2'b01;
            else if (in_wait && state_d == ERROR) err_code_o <= 2'b10;
            else if (state == ERROR && start_i) err_code_o <= 2'b00;
        end
    end
endmodule

// File: tb/tb_ascon_frame_sched.sv
// tb_ascon_frame_sched: randomized frames through a behavioural core, producer and consumer with scoreboarded ciphertext and tags
module tb_ascon_frame_sched;
    logic         clk = 1'b0;
    logic         reset_i = 1'b1;
    logic         start_i = 1'b0;
    logic [4:0]   nb_blocks_i = '0;
    logic [127:0] key_i = '0, nonce_i = '0, tag_i = '0;
    logic [63:0]  ad_i = '0, pt_data_i = '0, cipher_i = '0;
    logic         pt_valid_i = 1'b0, ct_ready_i = 1'b0;
    logic         end_initialisation_i = 1'b0, end_associate_i = 1'b0;
    logic         cipher_valid_i = 1'b0, end_cipher_i = 1'b0, end_tag_i = 1'b0;
    logic         pt_ready_o, init_o, associate_data_o, finalisation_o, data_valid_o;
    logic [63:0]  data_o, ct_data_o;
    logic [127:0] key_o, nonce_o, tag_o;
    logic         ct_valid_o, tag_valid_o, busy_o, err_o;
    logic [1:0]   err_code_o;

    ascon_frame_sched dut (
        .clock_i(clk), .reset_i(reset_i), .start_i(start_i), .nb_blocks_i(nb_blocks_i),
        .key_i(key_i), .nonce_i(nonce_i), .ad_i(ad_i), .pt_data_i(pt_data_i),
        .pt_valid_i(pt_valid_i), .pt_ready_o(pt_ready_o), .init_o(init_o),
        .associate_data_o(associate_data_o), .finalisation_o(finalisation_o),
        .data_o(data_o), .data_valid_o(data_valid_o), .key_o(key_o), .nonce_o(nonce_o),
        .end_initialisation_i(end_initialisation_i), .end_associate_i(end_associate_i),
        .cipher_i(cipher_i), .cipher_valid_i(cipher_valid_i), .end_cipher_i(end_cipher_i),
        .tag_i(tag_i), .end_tag_i(end_tag_i), .ct_data_o(ct_data_o), .ct_valid_o(ct_valid_o),
        .ct_ready_i(ct_ready_i), .tag_o(tag_o), .tag_valid_o(tag_valid_o), .busy_o(busy_o),
        .err_o(err_o), .err_code_o(err_code_o)
    );

    always #5 clk = ~clk;

    int           total = 0, bad = 0;
    logic [63:0]  pt_q[$], exp_ct[$];
    logic [127:0] exp_tag[$];
    logic [127:0] key, nonce;
    logic [63:0]  ad;
    int           rdy_mode = 0;
    bit           hold_ad = 1'b0;
    int           n_init = 0, n_ad = 0, n_pt = 0, n_fin = 0, n_tag = 0;
    int           b_init, b_ad, b_pt, b_fin, b_tag;

    // core's cipher transform and tag rule, as the bench defines its imaginary core
    function automatic logic [63:0] ct_of(input logic [63:0] p, input logic [127:0] k);
        return {p[31:0], p[63:32]} ^ k[127:64] ^ k[63:0];
    endfunction

    function automatic logic [127:0] tag_of(input logic [127:0] k, input logic [127:0] n, input logic [63:0] a, input logic [4:0] nb);
        return k ^ {n[63:0], n[127:64]} ^ {a, 59'd0, nb};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, want);
        end
    endtask

    task automatic chk_i(input string nm, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, want);
        end
    endtask

    // behavioural core: answers each strobe after a random latency
    int          c_init = 0, c_ad = 0, c_cv = 0, c_end = 0, blocks_seen = 0;
    bit          fin_blk = 1'b0;
    logic [63:0] cv_word = '0, ad_seen = '0;
    always @(negedge clk) begin
        end_initialisation_i = 1'b0;
        end_associate_i      = 1'b0;
        cipher_valid_i       = 1'b0;
        end_cipher_i         = 1'b0;
        end_tag_i            = 1'b0;
        if (reset_i) begin
            c_init = 0; c_ad = 0; c_cv = 0; c_end = 0; blocks_seen = 0;
        end else begin
            if (c_init == 1) end_initialisation_i = 1'b1;
            if (c_ad == 1) end_associate_i = 1'b1;
            if (c_cv == 1) begin
                cipher_valid_i = 1'b1;
                cipher_i       = cv_word;
            end
            if (c_end == 1) begin
                if (fin_blk) begin
                    end_tag_i = 1'b1;
                    tag_i     = tag_of(key_o, nonce_o, ad_seen, 5'(blocks_seen));
                end else end_cipher_i = 1'b1;
            end
            if (c_init > 0) c_init--;
            if (c_ad > 0) c_ad--;
            if (c_cv > 0) c_cv--;
            if (c_end > 0) c_end--;
            if (init_o) begin
                c_init      = $urandom_range(1, 5);
                blocks_seen = 0;
            end
            if (associate_data_o) begin
                ad_seen = data_o;
                if (!hold_ad) c_ad = $urandom_range(1, 5);
            end
            if (data_valid_o && !associate_data_o) begin
                blocks_seen++;
                fin_blk = finalisation_o;
                cv_word = ct_of(data_o, key_o);
                c_cv    = $urandom_range(1, 4);
                c_end   = c_cv + $urandom_range(0, 25);
            end
        end
    end

    // plaintext producer with random gaps
    logic [63:0] junk;
    always @(negedge clk) begin
        pt_valid_i = !reset_i && pt_q.size() != 0 && $urandom_range(0, 3) != 0;
        if (pt_valid_i) pt_data_i = pt_q[0];
        if (pt_valid_i && pt_ready_o) junk = pt_q.pop_front();
    end

    // consumer and monitor: ciphertext/tag scoreboard, stall stability, strobe counts
    int           stall_n = 0;
    bit           hold_v = 1'b0;
    logic [63:0]  hold_d = '0;
    logic [63:0]  want_ct;
    logic [127:0] want_tag;
    always @(negedge clk) begin
        if (reset_i) begin
            hold_v     = 1'b0;
            stall_n    = 0;
            ct_ready_i = 1'b0;
        end else begin
            if (hold_v) chk("ct_stable", {64'd0, ct_data_o}, {64'd0, hold_d});
            ct_ready_i = rdy_mode == 2 ? (stall_n >= 20) : (rdy_mode == 1 ? 1'b1 : ($urandom_range(0, 2) != 0));
            hold_v = 1'b0;
            if (ct_valid_o && !ct_ready_i) begin
                stall_n++;
                hold_v = 1'b1;
                hold_d = ct_data_o;
            end else stall_n = 0;
            if (ct_valid_o && ct_ready_i) begin
                if (exp_ct.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL ct_extra: got %h want no word", ct_data_o);
                end else begin
                    want_ct = exp_ct.pop_front();
                    chk("ct_word", {64'd0, ct_data_o}, {64'd0, want_ct});
                end
            end
            if (tag_valid_o) begin
                n_tag++;
                if (exp_tag.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL tag_extra: got %h want no tag", tag_o);
                end else begin
                    want_tag = exp_tag.pop_front();
                    chk("tag", tag_o, want_tag);
                end
            end
            if (init_o) n_init++;
            if (associate_data_o) n_ad++;
            if (data_valid_o && !associate_data_o && !finalisation_o) n_pt++;
            if (data_valid_o && finalisation_o) n_fin++;
        end
    end

    task automatic check_reset(input string nm);
        chk({nm, "_strobes"}, {119'd0, init_o, associate_data_o, finalisation_o, data_valid_o,
            pt_ready_o, ct_valid_o, tag_valid_o, busy_o, err_o}, '0);
        chk({nm, "_data"}, {64'd0, data_o}, '0);
        chk({nm, "_ct"}, {64'd0, ct_data_o}, '0);
        chk({nm, "_tag"}, tag_o, '0);
        chk({nm, "_key"}, key_o, '0);
        chk({nm, "_nonce"}, nonce_o, '0);
        chk({nm, "_code"}, {126'd0, err_code_o}, '0);
    endtask

    task automatic start_frame(input logic [4:0] nb, input bit load);
        logic [63:0] p;
        key   = {$urandom, $urandom, $urandom, $urandom};
        nonce = {$urandom, $urandom, $urandom, $urandom};
        ad    = {$urandom, $urandom};
        b_init = n_init; b_ad = n_ad; b_pt = n_pt; b_fin = n_fin; b_tag = n_tag;
        if (load) begin
            for (int i = 0; i < int'(nb); i++) begin
                p = {$urandom, $urandom};
                pt_q.push_back(p);
                exp_ct.push_back(ct_of(p, key));
            end
            exp_tag.push_back(tag_of(key, nonce, ad, nb));
        end
        start_i = 1'b1; nb_blocks_i = nb; key_i = key; nonce_i = nonce; ad_i = ad;
        @(posedge clk); #1;
        start_i = 1'b0; key_i = ~key; nonce_i = ~nonce; ad_i = ~ad; nb_blocks_i = ~nb;
    endtask

    task automatic run_frame(input int nb, input int mode, input string nm);
        int n = 0;
        rdy_mode = mode;
        start_frame(5'(nb), 1'b1);
        chk({nm, "_key"}, key_o, key);
        chk({nm, "_nonce"}, nonce_o, nonce);
        while ((busy_o || exp_ct.size() != 0 || exp_tag.size() != 0) && n < 6000) begin
            @(posedge clk); #1;
            n++;
        end
        chk_i({nm, "_finished_in_budget"}, int'(n < 6000), 1);
        repeat (2) @(posedge clk);
        #1;
        chk_i({nm, "_init_pulses"}, n_init - b_init, 1);
        chk_i({nm, "_ad_strobes"}, n_ad - b_ad, 1);
        chk_i({nm, "_pt_strobes"}, n_pt - b_pt, nb - 1);
        chk_i({nm, "_fin_strobes"}, n_fin - b_fin, 1);
        chk_i({nm, "_tag_strobes"}, n_tag - b_tag, 1);
        chk({nm, "_idle"}, {126'd0, busy_o, tag_valid_o}, '0);
    endtask

    task automatic bad_len(input logic [4:0] nb);
        start_frame(nb, 1'b0);
        chk("badlen_err", {125'd0, err_o, err_code_o}, 128'b101);
        chk("badlen_busy", {127'd0, busy_o}, '0);
        repeat (5) @(posedge clk);
        #1;
        chk_i("badlen_no_init", n_init - b_init, 0);
        chk("badlen_sticky", {127'd0, err_o}, 128'd1);
        start_i = 1'b1; nb_blocks_i = 5'd4;
        @(posedge clk); #1;
        start_i = 1'b0;
        chk("badlen_cleared", {124'd0, busy_o, err_o, err_code_o}, '0);
        repeat (5) @(posedge clk);
        #1;
        chk_i("badlen_no_frame", n_init - b_init, 0);
    endtask

    task automatic timeout_test();
        int n = 0, k = 0;
        hold_ad = 1'b1;
        start_frame(5'd2, 1'b0);
        while (!associate_data_o && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk_i("tmo_reach_ad", int'(associate_data_o), 1);
        while (!err_o && k < 2000) begin
            @(posedge clk); #1;
            k++;
        end
        chk_i("tmo_cycles_after_wait_ad", k - 1, 1023);
        chk("tmo_code", {126'd0, err_code_o}, 128'b10);
        hold_ad = 1'b0;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        chk("tmo_cleared", {124'd0, busy_o, err_o, err_code_o}, '0);
    endtask

    task automatic reset_mid_frame();
        int k = 0, n = 0;
        rdy_mode = 0;
        start_frame(5'd8, 1'b1);
        while (k < 5 && n < 3000) begin
            @(posedge clk); #1;
            n++;
            if (data_valid_o && !associate_data_o && !finalisation_o) k++;
        end
        chk_i("rst_reach_block5", k, 5);
        @(posedge clk); #1;
        chk("rst_in_wait_cipher", {126'd0, busy_o, data_valid_o || pt_ready_o || ct_valid_o}, 128'b10);
        reset_i = 1'b1;
        pt_q.delete();
        exp_ct.delete();
        exp_tag.delete();
        @(posedge clk); #1;
        reset_i = 1'b0;
        check_reset("midrst");
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset_i = 1'b0;
        check_reset("por");
        run_frame(1, 0, "one_block");
        run_frame(23, 1, "max_blocks");
        run_frame(3, 2, "stalled");
        for (int i = 0; i < 6; i++) run_frame($urandom_range(1, 23), $urandom_range(0, 1), "random");
        bad_len(5'd0);
        bad_len(5'd24);
        timeout_test();
        reset_mid_frame();
        run_frame(4, 0, "after_reset");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
